// File: rtl/piso_shifter.sv
// Parallel-in/serial-out stage: accepts a word on L & RDY and shifts it out one
// bit per enabled clock, with a serial-valid qualifier and an end-of-word pulse.
module piso_shifter #(
  parameter int N         = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic         C,
  input  logic         R,
  input  logic [N-1:0] D,
  input  logic         L,
  output logic         RDY,
  input  logic         EN,
  output logic         SO,
  output logic         SV,
  output logic         DONE
);

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t        state, state_nx;
  logic [N-1:0]  sr, sr_nx, sr_shifted;
  logic [CW-1:0] cnt, cnt_nx;
  logic          done_q, done_nx;
  logic          armed;
  logic          last_bit;
  logic          load;

  // armed keeps RDY low until the first clock edge after reset is released
  always_ff @(posedge C or posedge R) begin
    if (R) armed <= 1'b0;
    else   armed <= 1'b1;
  end

  assign last_bit   = (state == SHIFT) && (cnt == LAST) && EN;
  assign RDY        = armed && ((state == IDLE) || last_bit);
  assign load       = L && RDY;
  assign sr_shifted = MSB_FIRST ? {sr[N-2:0], 1'b0} : {1'b0, sr[N-1:1]};

  always_comb begin
    state_nx = state;
    sr_nx    = sr;
    cnt_nx   = cnt;
    done_nx  = 1'b0;
    case (state)
      IDLE: begin
        if (load) begin
          sr_nx    = D;
          cnt_nx   = '0;
          state_nx = SHIFT;
        end
      end
      SHIFT: begin
        if (EN) begin
          sr_nx  = sr_shifted;
          cnt_nx = cnt + CW'(1);
          if (cnt == LAST) begin
            done_nx = 1'b1;
            // a load on the last-bit edge keeps the stream gapless
            if (load) begin
              sr_nx  = D;
              cnt_nx = '0;
            end else begin
              cnt_nx   = '0;
              state_nx = IDLE;
            end
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge C or posedge R) begin
    if (R) begin
      state  <= IDLE;
      sr     <= '0;
      cnt    <= '0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nx;
      sr     <= sr_nx;
      cnt    <= cnt_nx;
      done_q <= done_nx;
    end
  end

  assign SV   = (state == SHIFT);
  assign SO   = (state == SHIFT) && (MSB_FIRST ? sr[N-1] : sr[0]);
  assign DONE = done_q;

endmodule

// File: tb/tb_piso_shifter.sv
// Scoreboard bench for piso_shifter: one MSB-first and one LSB-first instance,
// expected bit streams queued at load time and checked by a negedge monitor.
module tb_piso_shifter;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] dm, dl;
  logic       lm, ll, enm, enl;
  logic       rdym, som, svm, donem;
  logic       rdyl, sol, svl, donel;

  int checks = 0;
  int errors = 0;

  // each entry: {expected bit, last-bit-of-word flag}
  logic [1:0] qm[$];
  logic [1:0] ql[$];
  logic       pend[2];
  int         run[2];
  int         last_run[2];

  piso_shifter #(.N(8), .MSB_FIRST(1'b1)) dut_m (
    .C(clk), .R(rst), .D(dm), .L(lm), .RDY(rdym), .EN(enm),
    .SO(som), .SV(svm), .DONE(donem)
  );

  piso_shifter #(.N(8), .MSB_FIRST(1'b0)) dut_l (
    .C(clk), .R(rst), .D(dl), .L(ll), .RDY(rdyl), .EN(enl),
    .SO(sol), .SV(svl), .DONE(donel)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mon(input int s, input logic sv, input logic so, input logic en, input logic done);
    logic [1:0] head;
    int         depth;
    chk(s == 0 ? "done_m" : "done_l", {31'd0, done}, {31'd0, pend[s]});
    pend[s] = 1'b0;
    depth = (s == 0) ? qm.size() : ql.size();
    if (sv) begin
      run[s]++;
      if (depth == 0) begin
        chk(s == 0 ? "sv_unexpected_m" : "sv_unexpected_l", {31'd0, sv}, 32'd0);
      end else begin
        head = (s == 0) ? qm[0] : ql[0];
        chk(s == 0 ? "so_m" : "so_l", {31'd0, so}, {31'd0, head[1]});
        if (en) begin
          if (s == 0) void'(qm.pop_front());
          else        void'(ql.pop_front());
          pend[s] = head[0];
        end
      end
    end else begin
      if (run[s] != 0) last_run[s] = run[s];
      run[s] = 0;
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      pend[0] = 1'b0;
      pend[1] = 1'b0;
      run[0]  = 0;
      run[1]  = 0;
    end else begin
      mon(0, svm, som, enm, donem);
      mon(1, svl, sol, enl, donel);
    end
  end

  // queues the expected serial order, then waits for RDY and issues the load
  task automatic load_word(input int s, input logic [7:0] w, input bit hold);
    int    waited;
    logic  r;
    if (s == 0) begin lm = 1'b1; dm = w; end
    else        begin ll = 1'b1; dl = w; end
    #1;
    waited = 0;
    r = (s == 0) ? rdym : rdyl;
    while (!r && waited < 50) begin
      @(posedge clk);
      #2;
      waited++;
      r = (s == 0) ? rdym : rdyl;
    end
    if (!r) begin
      chk("load_timeout", {31'd0, r}, 32'd1);
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (s == 0) qm.push_back({w[7 - i], (i == 7)});
        else        ql.push_back({w[i], (i == 7)});
      end
      step();
      chk(s == 0 ? "latency_m" : "latency_l", {31'd0, (s == 0) ? svm : svl}, 32'd1);
    end
    if (!hold) begin
      if (s == 0) lm = 1'b0;
      else        ll = 1'b0;
    end
  endtask

  task automatic drain(input int s);
    int depth;
    for (int i = 0; i < 100; i++) begin
      step();
      depth = (s == 0) ? qm.size() : ql.size();
      if (depth == 0 && ((s == 0) ? !svm : !svl)) break;
    end
    chk(s == 0 ? "drain_m" : "drain_l", (s == 0) ? qm.size() : ql.size(), 32'd0);
    step();
  endtask

  task automatic applyStimulus();
    // power-on reset, released mid-cycle
    rst = 1'b1; lm = 1'b0; ll = 1'b0; dm = '0; dl = '0; enm = 1'b1; enl = 1'b1;
    #3;
    chk("rst_so", {31'd0, som}, 32'd0);
    chk("rst_sv", {31'd0, svm}, 32'd0);
    chk("rst_done", {31'd0, donem}, 32'd0);
    chk("rst_rdy", {31'd0, rdym}, 32'd0);
    @(posedge clk);
    #2 rst = 1'b0;
    step();
    chk("rdy_after_release", {31'd0, rdym}, 32'd1);

    // A5 MSB-first with EN held
    load_word(0, 8'hA5, 1'b0);
    drain(0);

    // same word with a three-cycle stall starting at k+3
    load_word(0, 8'hA5, 1'b0);
    step();
    step();
    enm = 1'b0;
    step(); step(); step();
    enm = 1'b1;
    drain(0);

    // back-to-back A5 then 3C with L held
    load_word(0, 8'hA5, 1'b1);
    load_word(0, 8'h3C, 1'b0);
    drain(0);
    chk("b2b_sv_run", last_run[0], 32'd16);

    // LSB-first instance
    load_word(1, 8'h01, 1'b0);
    drain(1);
    load_word(1, 8'h80, 1'b0);
    drain(1);

    // load attempt while busy must be ignored
    load_word(0, 8'hA5, 1'b0);
    step(); step();
    chk("busy_rdy", {31'd0, rdym}, 32'd0);
    lm = 1'b1; dm = 8'hFF;
    step();
    lm = 1'b0;
    drain(0);
    chk("busy_idle_sv", {31'd0, svm}, 32'd0);
    chk("busy_idle_rdy", {31'd0, rdym}, 32'd1);

    // reset in the middle of a word
    load_word(0, 8'hA5, 1'b0);
    step(); step(); step(); step();
    #1 rst = 1'b1;
    #1;
    chk("midrst_sv", {31'd0, svm}, 32'd0);
    chk("midrst_so", {31'd0, som}, 32'd0);
    chk("midrst_done", {31'd0, donem}, 32'd0);
    chk("midrst_rdy", {31'd0, rdym}, 32'd0);
    qm.delete();
    @(posedge clk);
    #2 rst = 1'b0;
    step();
    chk("midrst_rdy_back", {31'd0, rdym}, 32'd1);
    load_word(0, 8'h0F, 1'b0);
    drain(0);
  endtask

  task automatic checkOutput();
    chk("final_q_m", qm.size(), 32'd0);
    chk("final_q_l", ql.size(), 32'd0);
    chk("final_sv_l", {31'd0, svl}, 32'd0);
  endtask

  initial begin
    applyStimulus();
    checkOutput();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
